// File: rtl/dmem_arbiter.sv
// Arbiter that shares one single-ported data memory between the CPU MEM stage and a DMA/debug requester.
// Each grant is a fixed four-cycle sequence: sample (IDLE), address setup, access, acknowledge.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  // state  | meaning
  // IDLE   | sample requests, pick and latch the winner
  // GRANT  | drive latched address/data, read enable only
  // ACCESS | one-cycle write strobe, or read capture
  // RESP   | one-cycle ack to the owner
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner_q;
  logic            last_owner;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   cpu_rdata_q;
  logic [DW-1:0]   dma_rdata_q;
  logic            any_req;
  logic            win_dma;

  assign any_req = cpu_req | dma_req;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    win_dma = dma_req;
    if (cpu_req && dma_req) begin
      win_dma = CPU_PRIORITY ? 1'b0 : !last_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = ACCESS;
        mem_re    = !we_q;
      end
      ACCESS: begin
        state_nxt = RESP;
        mem_we    = we_q;
        mem_re    = !we_q;
      end
      RESP: begin
        state_nxt = IDLE;
        cpu_ack   = !owner_q;
        dma_ack   = owner_q;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= 1'b0;
      last_owner  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner_q <= win_dma;
        we_q    <= win_dma ? dma_we    : cpu_we;
        addr_q  <= win_dma ? dma_addr  : cpu_addr;
        wdata_q <= win_dma ? dma_wdata : cpu_wdata;
      end
      if (state == ACCESS && !we_q) begin
        if (owner_q) begin
          dma_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
      if (state == RESP) begin
        last_owner <= owner_q;
      end
    end
  end

  // Memory address/data come straight from the latches so late input changes cannot leak in.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed handshake scenarios plus random traffic, checked every cycle
// against a transaction-level model that predicts outputs from the grant time of each request.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy, owner;

  logic        p_cpu_req = 1'b0, p_dma_req = 1'b0;
  logic        p_cpu_ack, p_dma_ack, p_mem_we, p_mem_re, p_busy, p_owner;
  logic [31:0] p_cpu_rdata, p_dma_rdata, p_mem_addr, p_mem_wdata;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  dmem_arbiter #(.AW(32), .DW(32), .CPU_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  dmem_arbiter #(.AW(32), .DW(32), .CPU_PRIORITY(1'b1)) dut_pri (
    .clk(clk), .rst(rst),
    .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(32'h0000_0100), .cpu_wdata(32'h0),
    .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
    .dma_req(p_dma_req), .dma_we(1'b0), .dma_addr(32'h0000_0200), .dma_wdata(32'h0),
    .dma_ack(p_dma_ack), .dma_rdata(p_dma_rdata),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we), .mem_re(p_mem_re),
    .mem_rdata(p_mem_addr), .busy(p_busy), .owner(p_owner)
  );

  int          total = 0, bad = 0;
  int          cyc = 0, free_at = 0, start = 0;
  bit          t_owner, t_we, last_owner = 1'b1;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] e_cpu_rdata = '0, e_dma_rdata = '0;
  logic [31:0] ref_mem [256];
  bit          obs_cpu_ack, obs_dma_ack, rand_mode = 1'b0;
  int          n_cpu_ack = 0, n_dma_ack = 0, n_pcpu_ack = 0, n_pdma_ack = 0;
  int          last_cpu_at = -1000, last_dma_at = -1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A request sampled in period s owns the memory for s+1..s+3: address in s+1, strobe in s+2, ack in s+3.
  task automatic model_cycle();
    int ph;
    bit e_busy, e_cack, e_dack, e_we, e_re;
    ph = -1; e_busy = 0; e_cack = 0; e_dack = 0; e_we = 0; e_re = 0;
    if (cyc < free_at) begin
      ph = cyc - start;
      e_busy = 1;
      case (ph)
        1: e_re = !t_we;
        2: begin e_we = t_we; e_re = !t_we; end
        3: begin e_cack = !t_owner; e_dack = t_owner; end
        default: ;
      endcase
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
    chk("dma_ack", 32'(dma_ack), 32'(e_dack));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("dma_rdata", dma_rdata, e_dma_rdata);
    if (e_busy) chk("owner", 32'(owner), 32'(t_owner));
    if (ph == 1 || ph == 2) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_wdata", mem_wdata, t_wdata);
    end
    if (ph == 2) begin
      if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
      else if (t_owner) e_dma_rdata = ref_mem[t_addr[7:0]];
      else e_cpu_rdata = ref_mem[t_addr[7:0]];
    end
    if (ph == 3) last_owner = t_owner;
    if (!rst) begin
      free_at = cyc + 1;
      last_owner = 1'b1;
      e_cpu_rdata = '0;
      e_dma_rdata = '0;
    end else if (cyc >= free_at && (cpu_req || dma_req)) begin
      if (cpu_req && dma_req) t_owner = !last_owner;
      else t_owner = dma_req;
      t_we    = t_owner ? dma_we : cpu_we;
      t_addr  = t_owner ? dma_addr : cpu_addr;
      t_wdata = t_owner ? dma_wdata : cpu_wdata;
      start   = cyc;
      free_at = cyc + 4;
    end
  endtask

  task automatic drive_random();
    if (!(cpu_req && !obs_cpu_ack)) begin
      cpu_req   = ($urandom_range(0, 2) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
    end
    if (!(dma_req && !obs_dma_ack)) begin
      dma_req   = ($urandom_range(0, 2) == 0);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = $urandom;
      dma_wdata = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    chk("ack_excl", 32'(cpu_ack & dma_ack), 32'(0));
    obs_cpu_ack = cpu_ack;
    obs_dma_ack = dma_ack;
    if (cpu_ack) begin n_cpu_ack++; last_cpu_at = cyc; end
    if (dma_ack) begin n_dma_ack++; last_dma_at = cyc; end
    if (p_cpu_ack) n_pcpu_ack++;
    if (p_dma_ack) n_pdma_ack++;
    cyc++;
    @(posedge clk);
    #1;
    if (rand_mode) drive_random();
  endtask

  task automatic wait_cpu_ack(input int limit);
    int n = 0;
    do begin tick(); n++; end while (!obs_cpu_ack && n < limit);
    chk("cpu_ack_seen", 32'(obs_cpu_ack), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, a, n;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + i * 32'h0101_0101;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    end
    @(posedge clk);
    #1;
    tick();
    rst = 1'b1;

    // single CPU write then read back
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; cpu_req = 1'b1;
    s = cyc;
    wait_cpu_ack(10);
    cpu_req = 1'b0;
    chk("wr_latency", 32'(last_cpu_at - s), 32'd3);
    cpu_we = 1'b0; cpu_req = 1'b1;
    wait_cpu_ack(10);
    cpu_req = 1'b0;
    chk("rd_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("dma_rdata_idle", dma_rdata, 32'h0);

    // simultaneous requests right after reset: CPU first, DMA four cycles later
    do_reset();
    last_cpu_at = -1000; last_dma_at = -1000;
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 32'h24; dma_req = 1'b1;
    s = cyc; n = 0;
    do begin
      tick(); n++;
      if (obs_cpu_ack) cpu_req = 1'b0;
      if (obs_dma_ack) dma_req = 1'b0;
    end while (dma_req && n < 15);
    cpu_req = 1'b0; dma_req = 1'b0;
    chk("sim_cpu_at", 32'(last_cpu_at - s), 32'd3);
    chk("sim_dma_at", 32'(last_dma_at - s), 32'd7);

    // continuous contention: round-robin alternates, priority instance serves only the CPU
    do_reset();
    n_cpu_ack = 0; n_dma_ack = 0; n_pcpu_ack = 0; n_pdma_ack = 0;
    cpu_we = 1'b0; cpu_addr = 32'h50; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 32'h54; dma_req = 1'b1;
    p_cpu_req = 1'b1; p_dma_req = 1'b1;
    repeat (32) tick();
    cpu_req = 1'b0; dma_req = 1'b0; p_cpu_req = 1'b0; p_dma_req = 1'b0;
    chk("rr_cpu_grants", 32'(n_cpu_ack), 32'd4);
    chk("rr_dma_grants", 32'(n_dma_ack), 32'd4);
    chk("pri_cpu_grants", 32'(n_pcpu_ack), 32'd8);
    chk("pri_dma_grants", 32'(n_pdma_ack), 32'd0);

    // address/data changed after the IDLE sample must not affect the write
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h5; cpu_req = 1'b1;
    tick();
    cpu_addr = 32'h34; cpu_wdata = 32'h77;
    wait_cpu_ack(10);
    cpu_req = 1'b0;
    chk("late_chg_30", mem[8'h30], 32'h5);
    chk("late_chg_34", mem[8'h34], ref_mem[8'h34]);

    // req held after ack is a fresh request
    cpu_we = 1'b0; cpu_addr = 32'h30; cpu_req = 1'b1;
    wait_cpu_ack(10);
    a = last_cpu_at;
    wait_cpu_ack(10);
    cpu_req = 1'b0;
    chk("b2b_gap", 32'(last_cpu_at - a), 32'd4);

    // reset during a DMA write suppresses the strobe
    dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hCAFE_F00D; dma_req = 1'b1;
    tick();
    rst = 1'b0; dma_req = 1'b0;
    tick();
    chk("rst_no_we", 32'(mem_we), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mem40", mem[8'h40], ref_mem[8'h40]);
    chk("rst_busy", 32'(busy), 32'd0);

    // random traffic from both requesters
    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
